// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer between the CPU MEM stage and a registered RAM:
// issues one-cycle strobes, waits out the read latency and reports completion.
module mem_access_ctrl #(
    parameter int unsigned DEPTH_WORDS = 32,
    parameter int unsigned READ_WAIT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic        bank,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [15:0] Address,
    output logic [15:0] WriteData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [15:0] ReadData,
    input  logic        AddressSrc
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] WAIT_INIT = 3'(READ_WAIT);

    logic [1:0]  state_q,     state_d;
    logic [2:0]  wait_q,      wait_d;
    logic        is_write_q,  is_write_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic        err_q,       err_d;
    logic [15:0] rdata_q,     rdata_d;
    logic        bank_q,      bank_d;
    logic [15:0] rd_count_q,  rd_count_d;
    logic [15:0] wr_count_q,  wr_count_d;
    logic [15:0] addr_q,      addr_d;
    logic [15:0] wdata_q,     wdata_d;
    logic        mem_read_q,  mem_read_d;
    logic        mem_write_q, mem_write_d;

    logic [15:0] req_idx;
    logic        in_range;

    assign req_idx  = req_addr >> 2;
    assign in_range = (32'(req_idx) < DEPTH_WORDS);

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        is_write_d  = is_write_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        bank_d      = bank_q;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (in_range) begin
                        addr_d      = req_addr;
                        wdata_d     = req_wdata;
                        is_write_d  = req_write;
                        mem_write_d = req_write;
                        mem_read_d  = ~req_write;
                        state_d     = S_ISSUE;
                    end else begin
                        // Rejected access completes immediately; the bus is left untouched.
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        bank_d  = AddressSrc;
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                if (is_write_q) begin
                    done_d     = 1'b1;
                    bank_d     = AddressSrc;
                    wr_count_d = wr_count_q + 16'd1;
                    state_d    = S_DONE;
                end else begin
                    wait_d  = WAIT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wait_d = wait_q - 3'd1;
                if (wait_q == 3'd1) begin
                    rdata_d    = ReadData;
                    rd_count_d = rd_count_q + 16'd1;
                    done_d     = 1'b1;
                    bank_d     = AddressSrc;
                    state_d    = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            is_write_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            bank_q      <= 1'b0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            is_write_q  <= is_write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            bank_q      <= bank_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign bank      = bank_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
    assign Address   = addr_q;
    assign WriteData = wdata_q;
    assign MemRead   = mem_read_q;
    assign MemWrite  = mem_write_q;

    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst)
        !(mem_read_q && mem_write_q));

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed table, multi-cycle corner sequences and
// randomized accesses checked against a transaction-level memory model.
module tb_mem_access_ctrl;

    localparam int DEPTH = 32;
    localparam int RW    = 1;
    localparam int SPC   = 3 + RW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr  = '0;
    logic [15:0] req_wdata = '0;
    logic        busy, done, err, bank, MemRead, MemWrite;
    logic [15:0] rdata, rd_count, wr_count, Address, WriteData;
    logic [15:0] ReadData = '0;
    logic        AddressSrc;
    logic        bank_sel = 1'b0;

    mem_access_ctrl #(.DEPTH_WORDS(DEPTH), .READ_WAIT(RW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata), .bank(bank),
        .rd_count(rd_count), .wr_count(wr_count),
        .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .ReadData(ReadData), .AddressSrc(AddressSrc)
    );

    always #5 clk = ~clk;

    // Registered data memory seen by the DUT
    logic [15:0] env_ram [0:65535];
    always @(posedge clk) begin
        if (MemWrite) env_ram[Address >> 2] <= WriteData;
        if (MemRead)  ReadData <= env_ram[Address >> 2];
    end
    assign AddressSrc = bank_sel;

    // Reference model state
    logic [15:0] ref_mem [int];
    logic [15:0] m_rd = '0, m_wr = '0, m_rdata = '0, m_addr = '0, m_wdata = '0;
    logic        m_bank = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic        w;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        b;
        logic        exp_err;
        logic [15:0] exp_rdata;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_rd(input int i);
        return ref_mem.exists(i) ? ref_mem[i] : 16'h0000;
    endfunction

    task automatic model_reset();
        m_rd = '0; m_wr = '0; m_rdata = '0; m_addr = '0; m_wdata = '0; m_bank = 1'b0;
    endtask

    task automatic do_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                             input logic b, input bit noisy, output logic err_o);
        int unsigned exp_lat, lat, n_rd, n_wr, n_both;
        bit seen, ok;
        int idx;
        idx = int'(a >> 2);
        ok  = (idx < DEPTH);
        exp_lat = !ok ? 0 : (w ? 1 : 1 + RW);
        bank_sel = b; req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0;
        if (ok) begin
            chk("Address", 32'(Address), 32'(a));
            chk("WriteData", 32'(WriteData), 32'(d));
        end else begin
            chk("Address_hold", 32'(Address), 32'(m_addr));
            chk("WriteData_hold", 32'(WriteData), 32'(m_wdata));
        end
        n_rd = 0; n_wr = 0; n_both = 0; seen = 1'b0; lat = 0;
        for (int k = 0; k <= 16; k++) begin
            if (MemRead) n_rd++;
            if (MemWrite) n_wr++;
            if (MemRead && MemWrite) n_both++;
            if (done) begin
                seen = 1'b1;
                lat  = k;
                break;
            end
            if (noisy) begin
                req_valid = 1'($urandom);
                req_write = 1'($urandom);
                req_addr  = 16'($urandom);
                req_wdata = 16'($urandom);
            end
            tick();
        end
        req_valid = 1'b0;
        err_o = err;
        if (ok) begin
            m_addr = a; m_wdata = d;
            if (w) begin
                ref_mem[idx] = d;
                m_wr++;
            end else begin
                m_rdata = ref_rd(idx);
                m_rd++;
            end
        end
        m_bank = b;
        chk("done_seen", 32'(seen), 1);
        chk("latency", lat, exp_lat);
        chk("err", 32'(err), 32'(!ok));
        chk("busy_in_done", 32'(busy), 1);
        chk("bank", 32'(bank), 32'(m_bank));
        chk("rdata", 32'(rdata), 32'(m_rdata));
        chk("rd_count", 32'(rd_count), 32'(m_rd));
        chk("wr_count", 32'(wr_count), 32'(m_wr));
        chk("MemRead_pulses", n_rd, (ok && !w) ? 1 : 0);
        chk("MemWrite_pulses", n_wr, (ok && w) ? 1 : 0);
        chk("strobes_both", n_both, 0);
        tick();
        chk("busy_after", 32'(busy), 0);
        chk("done_after", 32'(done), 0);
        chk("err_after", 32'(err), 0);
        chk("Address_after", 32'(Address), 32'(m_addr));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e;
        logic [15:0] wd;
        bit          dseen;
        int          acc [$];

        for (int i = 0; i < 65536; i++) env_ram[i] = '0;

        // Async reset before any clock edge
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_MemRead", 32'(MemRead), 0);
        chk("rst_MemWrite", 32'(MemWrite), 0);
        chk("rst_Address", 32'(Address), 0);
        chk("rst_WriteData", 32'(WriteData), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_bank", 32'(bank), 0);
        chk("rst_rd_count", 32'(rd_count), 0);
        chk("rst_wr_count", 32'(wr_count), 0);
        tick(); tick();
        rst = 1'b1;
        tick();

        tbl[0] = '{1'b1, 16'h0008, 16'h1234, 1'b0, 1'b0, 16'h0000};
        tbl[1] = '{1'b0, 16'h0008, 16'h0000, 1'b1, 1'b0, 16'h1234};
        tbl[2] = '{1'b0, 16'h0080, 16'h0000, 1'b0, 1'b1, 16'h1234};
        tbl[3] = '{1'b1, 16'h007C, 16'hBEEF, 1'b1, 1'b0, 16'h1234};
        tbl[4] = '{1'b0, 16'h007F, 16'h0000, 1'b0, 1'b0, 16'hBEEF};
        tbl[5] = '{1'b1, 16'h0080, 16'h5555, 1'b1, 1'b1, 16'hBEEF};
        tbl[6] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000};
        tbl[7] = '{1'b1, 16'hFFFE, 16'h7777, 1'b0, 1'b1, 16'h0000};
        tbl[8] = '{1'b0, 16'h0081, 16'h0000, 1'b0, 1'b1, 16'h0000};
        tbl[9] = '{1'b0, 16'h007C, 16'h0000, 1'b1, 1'b0, 16'hBEEF};
        for (int i = 0; i < 10; i++) begin
            do_access(tbl[i].w, tbl[i].addr, tbl[i].wdata, tbl[i].b, 1'b0, e);
            chk("tbl_err", 32'(e), 32'(tbl[i].exp_err));
            chk("tbl_rdata", 32'(rdata), 32'(tbl[i].exp_rdata));
        end

        // req_valid held high: loads accepted only every SPC cycles
        wd = 16'h0042;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0004; req_wdata = wd; bank_sel = 1'b0;
        for (int k = 0; k < 2 * SPC + 4; k++) begin
            tick();
            if (MemRead) acc.push_back(k);
        end
        req_valid = 1'b0;
        chk("hold_accepts", 32'(acc.size()), 3);
        for (int i = 0; i < acc.size(); i++) chk("hold_accept_at", 32'(acc[i]), 32'(i * SPC));
        for (int k = 0; k < 16 && busy; k++) tick();
        chk("hold_drain_idle", 32'(busy), 0);
        m_rd = m_rd + 16'd3; m_rdata = ref_rd(1); m_addr = 16'h0004; m_wdata = wd; m_bank = 1'b0;
        chk("hold_rdata", 32'(rdata), 32'(m_rdata));
        chk("hold_rd_count", 32'(rd_count), 32'(m_rd));

        // Reset during ISSUE of a load
        bank_sel = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0008;
        tick();
        req_valid = 1'b0;
        chk("rstA_MemRead_pre", 32'(MemRead), 1);
        rst = 1'b0;
        #1;
        model_reset();
        chk("rstA_MemRead", 32'(MemRead), 0);
        chk("rstA_busy", 32'(busy), 0);
        chk("rstA_done", 32'(done), 0);
        tick(); tick();
        rst = 1'b1;
        dseen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done || busy) dseen = 1'b1;
        end
        chk("rstA_no_done", 32'(dseen), 0);
        chk("rstA_rd_count", 32'(rd_count), 0);
        chk("rstA_rdata", 32'(rdata), 0);

        // Reset during WAIT of a load
        do_access(1'b1, 16'h000C, 16'h0C0C, 1'b0, 1'b0, e);
        bank_sel = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0008;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rstB_wait_busy", 32'(busy), 1);
        chk("rstB_wait_MemRead", 32'(MemRead), 0);
        rst = 1'b0;
        #1;
        model_reset();
        chk("rstB_busy", 32'(busy), 0);
        chk("rstB_done", 32'(done), 0);
        chk("rstB_wr_count", 32'(wr_count), 0);
        tick(); tick();
        rst = 1'b1;
        dseen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done || busy) dseen = 1'b1;
        end
        chk("rstB_no_done", 32'(dseen), 0);
        chk("rstB_rd_count", 32'(rd_count), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            logic        w, b;
            logic [15:0] a, d;
            w = 1'($urandom);
            b = 1'($urandom);
            d = 16'($urandom);
            if ($urandom_range(0, 4) != 0) a = 16'($urandom_range(0, 4 * DEPTH - 1));
            else                           a = 16'($urandom_range(4 * DEPTH, 65535));
            do_access(w, a, d, b, 1'b1, e);
            repeat ($urandom_range(0, 2)) tick();
        end

        // Store counter wrap, starting just below the top
        force dut.wr_count_q = 16'hFFFD;
        #1;
        release dut.wr_count_q;
        #1;
        m_wr = 16'hFFFD;
        chk("wrap_preload", 32'(wr_count), 32'hFFFD);
        for (int i = 0; i < 3; i++) do_access(1'b1, 16'h0010, 16'hA5A5, 1'b0, 1'b0, e);
        chk("wrap_wr_count", 32'(wr_count), 32'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
